// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master shift engine.
package spi_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_edge_detect.sv
// Classifies sclk transitions, seen in the clk domain, as leading or trailing
// relative to the clock idle level.
module spi_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sclk_i,
  input  logic cpol_i,
  output logic lead_o,
  output logic trail_o
);

  logic sclk_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sclk_q <= cpol_i;
    else       sclk_q <= sclk_i;
  end

  // A leading edge leaves the idle level, a trailing edge returns to it.
  assign lead_o  = (sclk_i != sclk_q) && (sclk_i != cpol_i);
  assign trail_o = (sclk_i != sclk_q) && (sclk_i == cpol_i);

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: owns chip-select, shifts mosi/miso on edges of the
// externally generated sclk, and hands a start/busy/done handshake to the host.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_W      = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  lsb_first_i,
  input  logic                  sclk_i,
  input  logic                  miso_i,
  output logic                  cs_o,
  output logic                  mosi_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] tx_q, rx_q, rx_data_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  cpol_l_q, cpha_l_q, lsb_l_q;
  logic                  cs_q, mosi_q, busy_q, done_q;

  logic                  cpol_sel, lead, trail, sample, shift, last;
  logic                  tx_bit_d;
  logic [DATA_WIDTH-1:0] rx_shift_d;

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w,
                                                    input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // Outside a transfer follow the live cpol so sclk_q tracks the idle level.
  assign cpol_sel = (state_q == IDLE) ? cpol_i : cpol_l_q;

  spi_edge_detect u_edge (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .sclk_i  (sclk_i),
    .cpol_i  (cpol_sel),
    .lead_o  (lead),
    .trail_o (trail)
  );

  assign sample     = cpha_l_q ? trail : lead;
  assign shift      = cpha_l_q ? lead  : trail;
  assign last       = (cnt_q == CNT_W'(DATA_WIDTH));
  assign tx_bit_d   = lsb_l_q ? tx_q[0] : tx_q[DATA_WIDTH-1];
  assign rx_shift_d = lsb_l_q ? {miso_i, rx_q[DATA_WIDTH-1:1]}
                              : {rx_q[DATA_WIDTH-2:0], miso_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      cnt_q     <= '0;
      cpol_l_q  <= 1'b0;
      cpha_l_q  <= 1'b0;
      lsb_l_q   <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cpol_l_q <= cpol_i;
            cpha_l_q <= cpha_i;
            lsb_l_q  <= lsb_first_i;
            rx_q     <= '0;
            cnt_q    <= '0;
            cs_q     <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= XFER;
            // cpha=0 needs the first bit set up before the first leading edge.
            if (cpha_i) begin
              tx_q <= tx_data_i;
            end else begin
              tx_q   <= advance(tx_data_i, lsb_first_i);
              mosi_q <= lsb_first_i ? tx_data_i[0] : tx_data_i[DATA_WIDTH-1];
            end
          end
        end
        XFER: begin
          if (cpha_l_q && last) begin
            state_q <= DONE;
          end else begin
            if (sample) begin
              rx_q  <= rx_shift_d;
              cnt_q <= cnt_q + CNT_W'(1);
            end
            // With cpha=0 the trail after the final sample only closes the sclk cycle.
            if (shift) begin
              if (!cpha_l_q && last) begin
                state_q <= DONE;
              end else begin
                mosi_q <= tx_bit_d;
                tx_q   <= advance(tx_q, lsb_l_q);
              end
            end
          end
        end
        DONE: begin
          rx_data_q <= rx_q;
          done_q    <= 1'b1;
          cs_q      <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cs_o      = cs_q;
  assign mosi_o    = mosi_q;
  assign rx_data_o = rx_data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench: a divider-based sclk generator driven by cs, plus a small
// slave model, around the shift engine.
module tb_spi_shift_engine;
  import spi_pkg::*;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic       sclk = 1'b0, sclk_p = 1'b0, miso;
  logic [7:0] tx_data = 8'h00;
  logic       cs_o, mosi_o, busy_o, done_o;
  logic [7:0] rx_data_o;
  int         div = 0, miso_sel = 0, gcnt = 0;
  int         n_chk = 0, n_err = 0;

  // monitor state
  int         edge_cnt = 0, rise_cnt = 0, done_cnt = 0, slv_idx = 0;
  logic       mosi_log [64];
  logic [7:0] slv_tx = 8'h96, slv_rx = 8'h00;
  logic       slv_miso = 1'b0;

  spi_shift_engine #(.DATA_WIDTH(8), .CNT_W(5)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .tx_data_i(tx_data),
    .cpol_i(cpol), .cpha_i(cpha), .lsb_first_i(lsb_first),
    .sclk_i(sclk), .miso_i(miso), .cs_o(cs_o), .mosi_o(mosi_o),
    .rx_data_o(rx_data_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // sclk generator: idles at cpol while cs high, half period = div+1 clk
  always @(posedge clk) begin
    if (cs_o !== 1'b0) begin
      sclk <= cpol;
      gcnt <= 0;
    end else if (gcnt >= div) begin
      sclk <= ~sclk;
      gcnt <= 0;
    end else begin
      gcnt <= gcnt + 1;
    end
  end

  assign miso = (miso_sel == 0) ? mosi_o : (miso_sel == 1) ? 1'b0 : slv_miso;

  // Edge log and slave: slave drives on falling sclk, samples on rising sclk.
  always @(negedge clk) begin
    sclk_p <= sclk;
    if (done_o === 1'b1) done_cnt <= done_cnt + 1;
    if (cs_o !== 1'b0) begin
      slv_idx <= 0;
    end else if (sclk !== sclk_p) begin
      mosi_log[edge_cnt[5:0]] <= mosi_o;
      edge_cnt <= edge_cnt + 1;
      if (sclk) begin
        rise_cnt <= rise_cnt + 1;
        slv_rx   <= {mosi_o, slv_rx[7:1]};
      end else begin
        slv_miso <= slv_tx[slv_idx[2:0]];
        slv_idx  <= slv_idx + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mosi at every other logged edge from e0+first, first one as bit 7
  function automatic logic [7:0] collect(input int e0, input int first);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < 8; k++) b[7-k] = mosi_log[(e0 + first + 2*k) & 63];
    return b;
  endfunction

  task automatic xfer(input logic [1:0] mode, input logic lsb, input logic [7:0] tx,
                      input int dv, input int msel, input int pulse_at,
                      output logic [7:0] rx, output int cyc, output int e0, output int nd);
    int d0;
    cpol = mode[1]; cpha = mode[0]; lsb_first = lsb; div = dv; miso_sel = msel;
    repeat (3) @(negedge clk);
    e0 = edge_cnt; d0 = done_cnt;
    tx_data = tx; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (done_o !== 1'b1 && cyc < 600) begin
      if (cyc == pulse_at) begin start = 1'b1; tx_data = ~tx; end
      else begin start = 1'b0; tx_data = tx; end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", done_o, 1'b1);
    rx = rx_data_o;
    repeat (3) @(negedge clk);
    nd = done_cnt - d0;
  endtask

  initial begin
    logic [7:0] rx;
    int cyc, e0, nd, r0, d0, n;

    repeat (3) @(negedge clk);
    chk("rst_cs", cs_o, 1'b1);
    chk("rst_mosi", mosi_o, 1'b0);
    chk("rst_rx", rx_data_o, 8'h00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    rst = 1'b0;

    // abort after the 4th sample edge
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; div = 3; miso_sel = 0;
    repeat (3) @(negedge clk);
    r0 = rise_cnt; d0 = done_cnt; n = 0;
    tx_data = 8'hC3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (rise_cnt - r0 < 4 && n < 300) begin @(negedge clk); n++; end
    chk("abort_reach4", (rise_cnt - r0 >= 4), 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_cs", cs_o, 1'b1);
    chk("abort_busy", busy_o, 1'b0);
    repeat (10) @(negedge clk);
    chk("abort_nodone", done_cnt - d0, 0);
    chk("abort_rx", rx_data_o, 8'h00);
    xfer(MODE0, 1'b0, 8'h5A, 3, 0, 0, rx, cyc, e0, nd);
    chk("post_abort_rx", rx, 8'h5A);

    // mode 0, MSB-first, divider 0, loopback
    xfer(MODE0, 1'b0, 8'hA5, 0, 0, 0, rx, cyc, e0, nd);
    chk("m0_rx", rx, 8'hA5);
    chk("m0_mosi", collect(e0, 0), 8'hA5);
    chk("m0_latency", (cyc <= 40), 1'b1);
    chk("m0_done_cnt", nd, 1);

    // same transfer with a start pulse mid-stream
    xfer(MODE0, 1'b0, 8'hA5, 0, 0, 6, rx, cyc, e0, nd);
    chk("mid_rx", rx, 8'hA5);
    chk("mid_mosi", collect(e0, 0), 8'hA5);
    chk("mid_done_cnt", nd, 1);

    // mode 3, LSB-first, slave returns 0x96
    cpol = 1'b1; cpha = 1'b1; div = 3;
    repeat (3) @(negedge clk);
    chk("m3_idle_pre", sclk, 1'b1);
    r0 = rise_cnt;
    xfer(MODE3, 1'b1, 8'h3C, 3, 2, 0, rx, cyc, e0, nd);
    chk("m3_rx", rx, 8'h96);
    chk("m3_slave_rx", slv_rx, 8'h3C);
    chk("m3_edges", edge_cnt - e0, 16);
    chk("m3_rises", rise_cnt - r0, 8);
    chk("m3_idle_post", sclk, 1'b1);

    // modes 1 and 2, divider 3, 0xFF out, miso held low
    xfer(MODE1, 1'b0, 8'hFF, 3, 1, 0, rx, cyc, e0, nd);
    chk("m1_rx", rx, 8'h00);
    chk("m1_mosi", collect(e0, 1), 8'hFF);
    chk("m1_edges", edge_cnt - e0, 16);
    xfer(MODE2, 1'b0, 8'hFF, 3, 1, 0, rx, cyc, e0, nd);
    chk("m2_rx", rx, 8'h00);
    chk("m2_mosi", collect(e0, 0), 8'hFF);
    chk("m2_edges", edge_cnt - e0, 16);

    // back-to-back with start held high
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; div = 0; miso_sel = 0;
    repeat (3) @(negedge clk);
    d0 = done_cnt; n = 0;
    tx_data = 8'h12; start = 1'b1;
    @(negedge clk);
    tx_data = 8'h34;
    while (done_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("b2b_rx1", rx_data_o, 8'h12);
    n = 0;
    while (cs_o === 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("b2b_cs_gap", (n >= 1 && n < 10), 1'b1);
    start = 1'b0; n = 0;
    while (done_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("b2b_rx2", rx_data_o, 8'h34);
    repeat (5) @(negedge clk);
    chk("b2b_done_cnt", done_cnt - d0, 2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- SPI master shift engine; sits directly downstream of the SPI clock generator.
- Owns chip-select: its cs output feeds the generator's cs, and the generated sclk returns as this block's sclk input.
- Detects sclk edges in the clk domain, drives mosi, samples miso, and presents a start/busy/done handshake to the host-side register block.
- Supports all four CPOL/CPHA modes and MSB- or LSB-first ordering.

Parameters:
- DATA_WIDTH, 8, bits per transfer (legal range 2..16)
- CNT_W, 5, width of the bit counter; must satisfy 2^CNT_W > DATA_WIDTH

Ports:
- clk  input  1  system clock; sclk is generated synchronously from it
- rst  input  1  synchronous, active-high reset
- start  input  1  transfer request; honoured only in IDLE
- tx_data  input  DATA_WIDTH  word to transmit; latched when start is accepted
- cpol  input  1  clock idle level; static while busy
- cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; static while busy
- lsb_first  input  1  1 = bit 0 shifted first
- sclk  input  1  serial clock from the clock generator
- miso  input  1  serial data in
- cs  output  1  active-low chip select; also feeds the clock generator
- mosi  output  1  serial data out
- rx_data  output  DATA_WIDTH  last received word; stable between done pulses
- busy  output  1  high from start acceptance until done
- done  output  1  single-cycle pulse when rx_data is updated

Behaviour:
- Reset values (rst high at a clk edge): cs=1, mosi=0, rx_data=0, busy=0, done=0, state=IDLE, bit counter=0, sclk_q=cpol.
- Reset mid-transfer aborts immediately: cs returns high next edge; rx_data is not updated; no done pulse.
- Edge detect:
  - sclk_q <= sclk every cycle.
  - lead = (sclk != sclk_q) and (sclk != cpol_l).
  - trail = (sclk != sclk_q) and (sclk == cpol_l).
  - Edges are acted on only in XFER.
- sample_edge = cpha_l ? trail : lead; shift_edge = the other edge.
- FSM states:
  - IDLE:
    - cs=1, busy=0.
    - If start=1: latch tx_data, cpol, cpha and lsb_first into the shift register / cpol_l / cpha_l / lsb_l.
    - Same edge: cs<=0, busy<=1, go to XFER.
    - If cpha=0, mosi <= first bit at the same edge (setup before the first leading edge). If cpha=1, mosi holds its previous value until the first lead.
  - XFER:
    - On sample_edge: shift miso into the receive register (MSB-first: into bit 0, shifting left; LSB-first: into bit DATA_WIDTH-1, shifting right); counter++.
    - On shift_edge: advance the tx register and put the next bit on mosi.
    - When cpha=0, the shift_edge following the final sample drives no new bit.
    - Exit to DONE:
      - cpha=1: on the cycle after sample number DATA_WIDTH.
      - cpha=0: on the trail following sample number DATA_WIDTH, so sclk completes its last cycle.
  - DONE: rx_data <= receive register, done=1 for exactly one cycle, cs<=1, busy<=0, go to IDLE.
- Minimum cs-high time is 1 clk. A start asserted in the DONE cycle is ignored; a start in the following IDLE cycle is accepted.
- start while busy is ignored and must not disturb the transfer.
- lead and trail cannot coincide. An edge arriving in the same cycle as the DONE transition is discarded.
- Counter width CNT_W; the counter cannot wrap because the transfer stops at DATA_WIDTH.

Decomposition:
- Package spi_pkg:
  - state enum (IDLE, XFER, DONE)
  - mode constants MODE0..MODE3 as {cpol,cpha}
  - default DATA_WIDTH
- One sub-module, spi_edge_detect: inputs clk, rst, sclk, cpol; outputs lead, trail. Contains sclk_q and the edge equations.

Test Plan:
- Mode 0, MSB-first, clkgen divider=000, tx_data=0xA5, miso looped to mosi:
  - rx_data=0xA5, done pulses once.
  - mosi sequence 1,0,1,0,0,1,0,1, each bit valid on the rising sclk edge.
  - cs low for the whole transfer; done within 40 clk of start.
- Mode 3 (cpol=1, cpha=1), LSB-first, tx_data=0x3C, miso driven by a slave model returning 0x96 LSB-first:
  - rx_data=0x96; sclk idles high before and after.
  - exactly 8 sample edges counted, all rising.
- Mode 1 and mode 2 at divider=011, tx_data=0xFF, miso held at 0:
  - rx_data=0x00, mosi constant 1.
  - cs rises only after the 16th sclk edge (mode 2) / the 16th edge (mode 1).
- Back-to-back: start held high continuously with tx 0x12 then 0x34:
  - two transfers; cs high for ≥1 clk between them.
  - done pulses exactly twice; rx_data 0x12 then 0x34 in loopback.
- Reset after the 4th sample edge:
  - cs=1 and busy=0 the next cycle; no done pulse; rx_data keeps its prior value of 0.
  - a subsequent start with 0x5A completes correctly.
- start pulsed during XFER: ignored; rx_data and the mosi sequence are identical to an undisturbed 0xA5 run.
